// File: rtl/ternary_weight_loader_pkg.sv
// rtl/ternary_weight_loader_pkg.sv - ternary code points and load FSM state type
package ternary_pkg;

  localparam logic [1:0] TERN_ZERO    = 2'b00;
  localparam logic [1:0] TERN_POS     = 2'b01;
  localparam logic [1:0] TERN_NEG     = 2'b11;
  localparam logic [1:0] TERN_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } load_state_e;

  function automatic logic tern_legal(input logic [1:0] code);
    logic legal;
    case (code)
      TERN_ZERO, TERN_POS, TERN_NEG: legal = 1'b1;
      TERN_ILLEGAL:                  legal = 1'b0;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/ternary_weight_loader_stage_sreg.sv
// rtl/ternary_weight_loader_stage_sreg.sv - IN_LEN x BEATS staging shift register
module weight_stage_sreg #(
  parameter int IN_LEN = 12,
  parameter int BEATS  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  input  logic [IN_LEN-1:0]       din,
  output logic [IN_LEN*BEATS-1:0] q
);

  logic [IN_LEN*BEATS-1:0] stage_q;

  // Oldest beat migrates toward the MSBs; newest lands at the LSBs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else if (shift_en) begin
      stage_q <= {stage_q[IN_LEN*BEATS-IN_LEN-1:0], din};
    end
  end

  assign q = stage_q;

endmodule

// File: rtl/ternary_weight_loader.sv
// rtl/ternary_weight_loader.sv - double-buffered ternary weight loader
// Optional illegal-code checker built when TERNARY_CHECK_EN is defined.
module ternary_weight_loader
  import ternary_pkg::*;
#(
  parameter int  IN_LEN  = 12,
  parameter int  OUT_LEN = 6,
  parameter int  WIDTH   = 2,
  localparam int TOTAL   = WIDTH * IN_LEN * OUT_LEN,
  localparam int BEATS   = WIDTH * OUT_LEN,
  localparam int CW      = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_LEN-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic              weights_valid,
  output logic [CW-1:0]     beat_cnt,
  output logic              err,
  output logic [TOTAL-1:0]  uo_weights
);

  load_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TOTAL-1:0] shadow_q;
  logic             wv_q;
  logic [TOTAL-1:0] staging;
  logic             accept;

  // A restart in LOAD drops the beat presented in the same cycle.
  assign accept = (state_q == LOAD) && in_valid && !start;

  weight_stage_sreg #(
    .IN_LEN(IN_LEN),
    .BEATS (BEATS)
  ) u_stage (
    .clk     (clk),
    .rst     (rst),
    .shift_en(accept),
    .din     (in_data),
    .q       (staging)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (start) begin
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == CW'(BEATS - 1)) state_d = COMMIT;
          else                         cnt_d   = cnt_q + CW'(1);
        end
      end
      COMMIT: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      wv_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == COMMIT) begin
        shadow_q <= staging;
        wv_q     <= 1'b1;
      end
    end
  end

`ifdef TERNARY_CHECK_EN
  logic beat_illegal;
  logic err_q;

  always_comb begin
    beat_illegal = 1'b0;
    for (int f = 0; f < IN_LEN / WIDTH; f++) begin
      if (!tern_legal(in_data[f*WIDTH +: WIDTH])) beat_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start && state_q != COMMIT) begin
      err_q <= 1'b0;
    end else if (accept && beat_illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy          = (state_q != IDLE);
  assign weights_valid = wv_q;
  assign beat_cnt      = cnt_q;
  assign uo_weights    = shadow_q;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// tb/tb_ternary_weight_loader.sv - scoreboard bench for ternary_weight_loader
module tb_ternary_weight_loader;

  localparam int TOTAL = 144;
  localparam int CW    = 4;
`ifdef TERNARY_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [11:0]      in_data = '0;
  logic             busy;
  logic             done;
  logic             weights_valid;
  logic [CW-1:0]    beat_cnt;
  logic             err;
  logic [TOTAL-1:0] uo_weights;

  int checks   = 0;
  int failures = 0;
  int ndone    = 0;
  logic [TOTAL-1:0] sb[$];
  logic [TOTAL-1:0] set_a;

  ternary_weight_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .busy         (busy),
    .done         (done),
    .weights_valid(weights_valid),
    .beat_cnt     (beat_cnt),
    .err          (err),
    .uo_weights   (uo_weights)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TOTAL-1:0] act, input logic [TOTAL-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [TOTAL-1:0] mkset(input logic [11:0] base);
    logic [TOTAL-1:0] v = '0;
    for (int i = 0; i < 12; i++) v = {v[TOTAL-13:0], base + 12'(i)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [11:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("beat_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every done pulse pops one expected set; shadow is visible the next cycle.
  initial begin
    logic [TOTAL-1:0] exp;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp = sb.pop_front();
          @(negedge clk);
          chk("commit_weights", uo_weights, exp);
          chk("commit_wvalid", TOTAL'(weights_valid), 1);
          chk("done_one_cycle", TOTAL'(done), 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TOTAL-1:0] v;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", TOTAL'(in_ready), 0);
    chk("rst_busy", TOTAL'(busy), 0);
    chk("rst_done", TOTAL'(done), 0);
    chk("rst_wvalid", TOTAL'(weights_valid), 0);
    chk("rst_cnt", TOTAL'(beat_cnt), 0);
    chk("rst_err", TOTAL'(err), 0);
    chk("rst_weights", uo_weights, 0);

    // 1: straight load 001..00C
    sb.push_back(mkset(12'h001));
    do_start();
    chk("t1_ready", TOTAL'(in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      beat(12'h001 + 12'(i));
      if (i == 4) chk("t1_cnt5", TOTAL'(beat_cnt), 5);
    end
    chk("t1_commit_busy", TOTAL'(busy), 1);
    chk("t1_cnt_hold", TOTAL'(beat_cnt), 11);
    chk("t1_commit_not_ready", TOTAL'(in_ready), 0);
    tick();
    tick();
    chk("t1_wvalid", TOTAL'(weights_valid), 1);
    chk("t1_idle", TOTAL'(busy), 0);

    // 2: valid toggling every cycle
    set_a = mkset(12'h100);
    sb.push_back(set_a);
    do_start();
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 12'h100 + 12'(i);
      tick();
      in_valid = 1'b0;
      in_data  = 12'hABC;
      chk("t2_cnt", TOTAL'(beat_cnt), TOTAL'(i < 11 ? i + 1 : 11));
      tick();
    end
    tick();

    // 3: shadow stable while B partially loads
    sb.push_back(mkset(12'h200));
    do_start();
    for (int i = 0; i < 12; i++) begin
      beat(12'h200 + 12'(i));
      if (i < 5) chk("t3_shadow_stable", uo_weights, set_a);
    end
    tick();
    tick();

    // 4: restart after 7 beats, same-cycle beat dropped
    do_start();
    for (int i = 0; i < 7; i++) beat(12'h300 + 12'(i));
    chk("t4_cnt7", TOTAL'(beat_cnt), 7);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 12'hFFF;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("t4_restart_cnt", TOTAL'(beat_cnt), 0);
    chk("t4_restart_ready", TOTAL'(in_ready), 1);
    sb.push_back(mkset(12'h400));
    for (int i = 0; i < 12; i++) beat(12'h400 + 12'(i));
    tick();
    tick();

    // 5: reset on the 4th beat
    do_start();
    for (int i = 0; i < 3; i++) beat(12'h500 + 12'(i));
    in_valid = 1'b1;
    in_data  = 12'h503;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("t5_ready", TOTAL'(in_ready), 0);
    chk("t5_busy", TOTAL'(busy), 0);
    chk("t5_done", TOTAL'(done), 0);
    chk("t5_wvalid", TOTAL'(weights_valid), 0);
    chk("t5_cnt", TOTAL'(beat_cnt), 0);
    chk("t5_err", TOTAL'(err), 0);
    chk("t5_weights", uo_weights, 0);

    // 6: illegal code on first beat
    v = '0;
    v = {v[TOTAL-13:0], 12'h002};
    for (int i = 0; i < 11; i++) v = {v[TOTAL-13:0], 12'h001};
    sb.push_back(v);
    do_start();
    beat(12'h002);
    chk("t6_err_set", TOTAL'(err), TOTAL'(EXP_ERR));
    for (int i = 0; i < 11; i++) beat(12'h001);
    tick();
    tick();
    chk("t6_err_held", TOTAL'(err), TOTAL'(EXP_ERR));
    do_start();
    chk("t6_err_cleared", TOTAL'(err), 0);

    repeat (5) tick();
    chk("sb_empty", TOTAL'(sb.size()), 0);
    chk("done_count", TOTAL'(ndone), 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
